// File: rtl/jtframe_cen_recover.sv
// jtframe_cen_recover: gates cen while the core waits on memory and re-issues the pulses it missed
module jtframe_cen_recover #(
  parameter int CW      = 4,
  parameter int GAP     = 2,
  parameter int RECOVER = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_in,
  input  logic          rom_cs,
  input  logic          rom_ok,
  input  logic          dev_busy,
  input  logic          clr_ovf,
  output logic          cen_out,
  output logic          stalled,
  output logic [CW-1:0] miss_cnt,
  output logic          overflow
);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {RUN, STALL, CATCHUP} state_t;
  state_t state, state_nx;
  logic [GW-1:0] gap;
  logic wt, inc, sat, ins, cen_nx;
  logic [CW-1:0] miss_nx;
  // next-state, pulse gating and missed-pulse bookkeeping
  always_comb begin
    wt = (rom_cs & ~rom_ok) | dev_busy;
    inc = wt & cen_in;
    sat = &miss_cnt;
    ins = state == CATCHUP && !wt && !cen_in && gap >= GW'(GAP) && miss_cnt != '0;
    cen_nx = !wt && (cen_in || ins);
    state_nx = wt ? STALL :
               state == STALL ? ((RECOVER != 0 && miss_cnt != '0) ? CATCHUP : RUN) :
               (state == CATCHUP && !(ins && miss_cnt == CW'(1))) ? CATCHUP : RUN;
    miss_nx = inc ? (sat ? miss_cnt : miss_cnt + CW'(1)) :
              (state == STALL && !wt && RECOVER == 0) ? '0 :
              ins ? miss_cnt - CW'(1) : miss_cnt;
  end
  // registered outputs; the gap counter spaces inserted pulses from any previous cen_out
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cen_out  <= 1'b0;
      stalled  <= 1'b0;
      miss_cnt <= '0;
      overflow <= 1'b0;
      gap      <= '0;
    end else begin
      state    <= state_nx;
      cen_out  <= cen_nx;
      stalled  <= wt;
      miss_cnt <= miss_nx;
      overflow <= (inc & sat) | (overflow & ~clr_ovf);
      gap      <= cen_nx ? '0 : (gap == GW'(GAP) ? gap : gap + GW'(1));
    end
  end
endmodule

// File: tb/tb_jtframe_cen_recover.sv
// tb_jtframe_cen_recover: vector table with scoreboard for default, CW=2 and RECOVER=0 instances
module tb_jtframe_cen_recover;
  logic clk = 0, rst = 1, cen_in = 0, rom_cs = 0, rom_ok = 0, dev_busy = 0, clr_ovf = 0;
  logic a_cen, a_st, a_ovf, b_cen, b_st, b_ovf, c_cen, c_st, c_ovf;
  logic [3:0] a_miss, c_miss;
  logic [1:0] b_miss;
  always #5 clk = ~clk;
  jtframe_cen_recover u_a (.clk(clk), .rst(rst), .cen_in(cen_in), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .dev_busy(dev_busy), .clr_ovf(clr_ovf), .cen_out(a_cen), .stalled(a_st), .miss_cnt(a_miss), .overflow(a_ovf));
  jtframe_cen_recover #(.CW(2)) u_b (.clk(clk), .rst(rst), .cen_in(cen_in), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .dev_busy(dev_busy), .clr_ovf(clr_ovf), .cen_out(b_cen), .stalled(b_st), .miss_cnt(b_miss), .overflow(b_ovf));
  jtframe_cen_recover #(.RECOVER(0)) u_c (.clk(clk), .rst(rst), .cen_in(cen_in), .rom_cs(rom_cs), .rom_ok(rom_ok),
    .dev_busy(dev_busy), .clr_ovf(clr_ovf), .cen_out(c_cen), .stalled(c_st), .miss_cnt(c_miss), .overflow(c_ovf));
  typedef struct {
    string name;
    logic cen, cs, ok, busy, clr, rs;
    int sel;
    logic [6:0] exp;
  } vec_t;
  typedef struct {
    string name;
    int idx;
    int sel;
    logic [6:0] exp;
  } sb_t;
  vec_t vecs[$];
  sb_t sbq[$];
  int checks = 0, errors = 0;
  function automatic void add(input string name, input logic c, cs, ok, busy, clr, rs, input int sel,
                              input logic ec, es, input logic [3:0] em, input logic eo);
    vec_t v;
    v.name = name; v.cen = c; v.cs = cs; v.ok = ok; v.busy = busy; v.clr = clr; v.rs = rs;
    v.sel = sel; v.exp = {ec, es, em, eo};
    vecs.push_back(v);
  endfunction
  function automatic void reset(input int sel);
    add("reset", 0, 0, 0, 0, 0, 1, sel, 0, 0, 0, 0);
    add("reset", 0, 0, 0, 0, 0, 1, sel, 0, 0, 0, 0);
  endfunction
  initial begin
    sb_t s;
    logic [6:0] act;
    reset(0);
    for (int i = 0; i < 30; i++) begin
      logic c;
      c = (i % 3 == 0);
      add("pass", c, i[0], 1, 0, 0, 0, 0, c, 0, 0, 0);
    end
    reset(0);
    for (int s2 = 0; s2 < 12; s2++)
      add("stall", (s2 % 3 == 0), 1, 0, 0, 0, 0, 0, 0, 1, 4'(s2 / 3 + 1), 0);
    for (int r = 0; r < 12; r++)
      add("recover", 0, 1, 1, 0, 0, 0, 0, (r % 3 == 1 && r <= 10), 0,
          r == 0 ? 4'd4 : 4'(4 - (r + 2) / 3), 0);
    reset(0);
    add("native_stall", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add("native_stall", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add("native_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("native_prio", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add("native_gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("native_gap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add("native_ins", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add("native_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset(1);
    for (int k = 0; k < 5; k++)
      add("sat_stall", 1, 1, 0, 0, 0, 0, 1, 0, 1, k > 2 ? 4'd3 : 4'(k + 1), k > 2);
    add("sat_clr_set", 1, 1, 0, 0, 1, 0, 1, 0, 1, 3, 1);
    for (int r = 0; r < 9; r++)
      add("sat_recover", 0, 0, 0, 0, 0, 0, 1, (r % 3 == 1), 0,
          r == 0 ? 4'd3 : 4'(3 - (r + 2) / 3), 1);
    add("sat_clr", 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add("sat_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    reset(2);
    for (int s2 = 0; s2 < 8; s2++)
      add("norec_stall", (s2 % 3 == 0), 1, 0, 0, 0, 0, 2, 0, 1, 4'(s2 / 3 + 1), 0);
    add("norec_exit", 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    for (int r = 1; r < 7; r++)
      add("norec_idle", r == 3, 0, 0, 0, 0, 0, 2, r == 3, 0, 0, 0);
    reset(0);
    for (int k = 0; k < 3; k++)
      add("rst_stall", 1, 1, 0, 0, 0, 0, 0, 0, 1, 4'(k + 1), 0);
    add("rst_catchup", 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    add("rst_mid", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++)
      add("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      cen_in = vecs[i].cen; rom_cs = vecs[i].cs; rom_ok = vecs[i].ok;
      dev_busy = vecs[i].busy; clr_ovf = vecs[i].clr; rst = vecs[i].rs;
      e.name = vecs[i].name; e.idx = i; e.sel = vecs[i].sel; e.exp = vecs[i].exp;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      s = sbq.pop_front();
      act = s.sel == 0 ? {a_cen, a_st, a_miss, a_ovf} :
            s.sel == 1 ? {b_cen, b_st, 2'b00, b_miss, b_ovf} : {c_cen, c_st, c_miss, c_ovf};
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s vec %0d dut %0d: got cen=%b st=%b miss=%0d ovf=%b, want cen=%b st=%b miss=%0d ovf=%b",
                 s.name, s.idx, s.sel, act[6], act[5], act[4:1], act[0], s.exp[6], s.exp[5], s.exp[4:1], s.exp[0]);
      end
    end
    cen_in = 0; rom_cs = 0; rom_ok = 0; dev_busy = 0; clr_ovf = 0; rst = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({a_cen, a_st, a_miss, a_ovf} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got cen=%b st=%b miss=%0d ovf=%b", a_cen, a_st, a_miss, a_ovf);
    end
    rst = 0; rom_cs = 1; rom_ok = 0;
    @(posedge clk);
    #1;
    rom_ok = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({a_cen, a_st, a_miss} !== 6'd0) begin
      errors++;
      $display("FAIL expired_wait: got cen=%b st=%b miss=%0d", a_cen, a_st, a_miss);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
